// File: rtl/trap_sequencer.sv
`default_nettype none
// ============================================================================
// trap_sequencer : RISC-V trap-entry / xRET CSR write and fetch-redirect FSM
// Rev 1.0
// ============================================================================
module trap_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_cause,
    input  logic [XLEN-1:0] trap_epc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            ret_valid,
    input  logic            ret_is_m,
    input  logic [XLEN-1:0] medeleg,
    input  logic [XLEN-1:0] mideleg,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] stvec,
    input  logic [XLEN-1:0] mepc_in,
    input  logic [XLEN-1:0] sepc_in,
    input  logic [XLEN-1:0] mstatus_in,
    output logic            csr_wen,
    output logic [11:0]     csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [1:0]      mode
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_EPC    = 3'd1,
        S_W_CAUSE  = 3'd2,
        S_W_TVAL   = 3'd3,
        S_W_STATUS = 3'd4,
        S_REDIR    = 3'd5
    } state_t;

    localparam logic [11:0] C_MEPC    = 12'h341;
    localparam logic [11:0] C_MCAUSE  = 12'h342;
    localparam logic [11:0] C_MTVAL   = 12'h343;
    localparam logic [11:0] C_MSTATUS = 12'h300;
    localparam logic [11:0] C_SEPC    = 12'h141;
    localparam logic [11:0] C_SCAUSE  = 12'h142;
    localparam logic [11:0] C_STVAL   = 12'h143;
    localparam logic [11:0] C_SSTATUS = 12'h100;

    state_t          state_q;
    logic            to_s_q;
    logic [XLEN-1:0] cause_q, tval_q, status_q, pc_q;
    logic [1:0]      nmode_q;

    logic            is_int, acc_s;
    logic [4:0]      code;
    logic [XLEN-1:0] deleg, tvec, offs, status_d, pc_d;
    logic [1:0]      nmode_d;

    // Everything the sequence needs is resolved on the accept cycle, so later
    // input changes cannot leak into the CSR writes or the redirect.
    always_comb begin
        is_int   = trap_cause[XLEN-1];
        code     = trap_cause[4:0];
        deleg    = is_int ? mideleg : medeleg;
        acc_s    = 1'b0;
        tvec     = '0;
        offs     = '0;
        status_d = mstatus_in;
        pc_d     = '0;
        nmode_d  = 2'b11;
        if (trap_valid) begin
            acc_s = (mode != 2'b11) && deleg[code];
            tvec  = acc_s ? stvec : mtvec;
            if (tvec[1:0] == 2'b01 && is_int)
                offs[6:0] = {code, 2'b00};
            pc_d = {tvec[XLEN-1:2], 2'b00} + offs;
            if (acc_s) begin
                status_d[5] = mstatus_in[1];
                status_d[1] = 1'b0;
                status_d[8] = mode[0];
                nmode_d     = 2'b01;
            end else begin
                status_d[7]     = mstatus_in[3];
                status_d[3]     = 1'b0;
                status_d[12:11] = mode;
            end
        end else if (ret_is_m) begin
            status_d[3]     = mstatus_in[7];
            status_d[7]     = 1'b1;
            status_d[12:11] = 2'b00;
            pc_d            = mepc_in;
            nmode_d         = (mstatus_in[12:11] == 2'b10) ? 2'b00 : mstatus_in[12:11];
        end else begin
            acc_s       = 1'b1;
            status_d[1] = mstatus_in[5];
            status_d[5] = 1'b1;
            status_d[8] = 1'b0;
            pc_d        = sepc_in;
            nmode_d     = {1'b0, mstatus_in[8]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            ready          <= 1'b1;
            csr_wen        <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            mode           <= 2'b11;
            to_s_q         <= 1'b0;
            cause_q        <= '0;
            tval_q         <= '0;
            status_q       <= '0;
            pc_q           <= '0;
            nmode_q        <= 2'b11;
        end else begin
            csr_wen        <= 1'b0;
            csr_waddr      <= '0;
            csr_wdata      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            case (state_q)
                S_IDLE: begin
                    if (trap_valid || ret_valid) begin
                        ready    <= 1'b0;
                        to_s_q   <= acc_s;
                        cause_q  <= trap_cause;
                        tval_q   <= trap_tval;
                        status_q <= status_d;
                        pc_q     <= pc_d;
                        nmode_q  <= nmode_d;
                        csr_wen  <= 1'b1;
                        if (trap_valid) begin
                            state_q   <= S_W_EPC;
                            csr_waddr <= acc_s ? C_SEPC : C_MEPC;
                            csr_wdata <= trap_epc;
                        end else begin
                            state_q   <= S_W_STATUS;
                            csr_waddr <= acc_s ? C_SSTATUS : C_MSTATUS;
                            csr_wdata <= status_d;
                        end
                    end
                end
                S_W_EPC: begin
                    state_q   <= S_W_CAUSE;
                    csr_wen   <= 1'b1;
                    csr_waddr <= to_s_q ? C_SCAUSE : C_MCAUSE;
                    csr_wdata <= cause_q;
                end
                S_W_CAUSE: begin
                    state_q   <= S_W_TVAL;
                    csr_wen   <= 1'b1;
                    csr_waddr <= to_s_q ? C_STVAL : C_MTVAL;
                    csr_wdata <= tval_q;
                end
                S_W_TVAL: begin
                    state_q   <= S_W_STATUS;
                    csr_wen   <= 1'b1;
                    csr_waddr <= to_s_q ? C_SSTATUS : C_MSTATUS;
                    csr_wdata <= status_q;
                end
                S_W_STATUS: begin
                    state_q        <= S_REDIR;
                    redirect_valid <= 1'b1;
                    redirect_pc    <= pc_q;
                end
                S_REDIR: begin
                    state_q <= S_IDLE;
                    ready   <= 1'b1;
                    mode    <= nmode_q;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_sequencer.sv
`default_nettype none
// tb_trap_sequencer : directed scoreboard bench for trap_sequencer
module tb_trap_sequencer;

    typedef struct packed {
        logic        rdy;
        logic        wen;
        logic [11:0] addr;
        logic [31:0] data;
        logic        rv;
        logic [31:0] pc;
        logic [1:0]  md;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic        trap_valid, ret_valid, ret_is_m;
    logic [31:0] trap_cause, trap_epc, trap_tval;
    logic [31:0] medeleg, mideleg, mtvec, stvec, mepc_in, sepc_in, mstatus_in;
    logic        csr_wen, redirect_valid;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata, redirect_pc;
    logic [1:0]  mode;

    obs_t q[$];
    logic [1:0] cur_mode = 2'b11;
    int n_assert = 0;
    int n_fail   = 0;

    trap_sequencer #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_epc(trap_epc),
        .trap_tval(trap_tval), .ret_valid(ret_valid), .ret_is_m(ret_is_m),
        .medeleg(medeleg), .mideleg(mideleg), .mtvec(mtvec), .stvec(stvec),
        .mepc_in(mepc_in), .sepc_in(sepc_in), .mstatus_in(mstatus_in),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mode(mode)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic r, logic w, logic [11:0] a, logic [31:0] d,
                                logic v, logic [31:0] p, logic [1:0] m);
        obs_t o;
        o = '{rdy: r, wen: w, addr: a, data: d, rv: v, pc: p, md: m};
        return o;
    endfunction

    task automatic compare(input string tag, input obs_t exp);
        obs_t obs;
        obs = '{rdy: ready, wen: csr_wen, addr: csr_waddr, data: csr_wdata,
                rv: redirect_valid, pc: redirect_pc, md: mode};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        if (q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty", tag);
        end else
            compare(tag, q.pop_front());
    endtask

    task automatic scramble(input bit pulse);
        trap_valid = pulse; ret_valid = pulse; ret_is_m = 1'($urandom);
        trap_cause = $urandom; trap_epc = $urandom; trap_tval = $urandom;
        medeleg = $urandom; mideleg = $urandom; mtvec = $urandom; stvec = $urandom;
        mepc_in = $urandom; sepc_in = $urandom; mstatus_in = $urandom;
    endtask

    task automatic drain(input string tag, input bit pulse);
        int guard;
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(negedge clk);
            pop_check(tag);
            scramble(pulse && q.size() >= 2);
            guard++;
        end
        trap_valid = 1'b0; ret_valid = 1'b0;
    endtask

    task automatic do_trap(input string tag, input logic [31:0] cause, epc, tval,
                           mdel, idel, mtv, stv, mst, input bit pulse, input bit exp_s,
                           input logic [31:0] exp_st, exp_pc, input logic [1:0] exp_md);
        logic [11:0] base;
        base = exp_s ? 12'h100 : 12'h300;
        q.push_back(mk(0, 1, base + 12'h041, epc,    0, 0, cur_mode));
        q.push_back(mk(0, 1, base + 12'h042, cause,  0, 0, cur_mode));
        q.push_back(mk(0, 1, base + 12'h043, tval,   0, 0, cur_mode));
        q.push_back(mk(0, 1, base,           exp_st, 0, 0, cur_mode));
        q.push_back(mk(0, 0, 0, 0, 1, exp_pc, cur_mode));
        q.push_back(mk(1, 0, 0, 0, 0, 0, exp_md));
        q.push_back(mk(1, 0, 0, 0, 0, 0, exp_md));
        cur_mode = exp_md;
        @(negedge clk);
        trap_valid = 1'b1; ret_valid = 1'b0; ret_is_m = 1'b1;
        trap_cause = cause; trap_epc = epc; trap_tval = tval;
        medeleg = mdel; mideleg = idel; mtvec = mtv; stvec = stv; mstatus_in = mst;
        drain(tag, pulse);
    endtask

    task automatic do_ret(input string tag, input bit is_m, input logic [31:0] mst,
                          mepc, sepc, exp_st, exp_pc, input logic [1:0] exp_md);
        q.push_back(mk(0, 1, is_m ? 12'h300 : 12'h100, exp_st, 0, 0, cur_mode));
        q.push_back(mk(0, 0, 0, 0, 1, exp_pc, cur_mode));
        q.push_back(mk(1, 0, 0, 0, 0, 0, exp_md));
        q.push_back(mk(1, 0, 0, 0, 0, 0, exp_md));
        cur_mode = exp_md;
        @(negedge clk);
        trap_valid = 1'b0; ret_valid = 1'b1; ret_is_m = is_m;
        mstatus_in = mst; mepc_in = mepc; sepc_in = sepc;
        drain(tag, 1'b0);
    endtask

    initial begin
        scramble(1'b0);
        reset = 1'b1;
        #12;
        compare("reset_state", mk(1, 0, 0, 0, 0, 0, 2'b11));
        @(negedge clk);
        reset = 1'b0;

        // MRET staying in M, then MRET down to U
        do_ret("mret_m", 1, 32'h0000_1880, 32'h100, 32'h0, 32'h88, 32'h100, 2'b11);
        do_ret("mret_u", 1, 32'h0000_0080, 32'h200, 32'h0, 32'h88, 32'h200, 2'b00);

        do_trap("trap_u_m", 32'd8, 32'h1234, 32'hDEAD, 32'h0, 32'h0, 32'h8000_0000,
                32'h4000_0001, 32'h8, 0, 0, 32'h80, 32'h8000_0000, 2'b11);

        do_ret("mret_u2", 1, 32'h0, 32'h300, 32'h0, 32'h80, 32'h300, 2'b00);
        do_trap("irq_u_s", 32'h8000_0005, 32'hAAA0, 32'h55, 32'h0, 32'h20, 32'h9000_0001,
                32'h4000_0001, 32'h2, 0, 1, 32'h20, 32'h4000_0014, 2'b01);

        do_ret("sret", 0, 32'h120, 32'h0, 32'h500, 32'h22, 32'h500, 2'b01);
        do_trap("exc_s_s", 32'd2, 32'h600, 32'h7, 32'h4, 32'h0, 32'h9000_0000,
                32'h4000_0001, 32'h22, 0, 1, 32'h120, 32'h4000_0000, 2'b01);

        do_ret("mret_s_m", 1, 32'h1800, 32'h700, 32'h0, 32'h80, 32'h700, 2'b11);
        do_trap("m_no_deleg", 32'd2, 32'h800, 32'h9, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                32'h8000_0101, 32'h4000_0001, 32'h8, 0, 0, 32'h1880, 32'h8000_0100, 2'b11);
        do_trap("vec_mode3", 32'h8000_0003, 32'h900, 32'h0, 32'h0, 32'h0,
                32'h8000_0103, 32'h0, 32'h0, 0, 0, 32'h1800, 32'h8000_0100, 2'b11);
        do_trap("busy_ignored", 32'd4, 32'hA00, 32'h1, 32'h0, 32'h0,
                32'hFFFF_FFFC, 32'h0, 32'h8, 1, 0, 32'h1880, 32'hFFFF_FFFC, 2'b11);
        do_ret("mret_h_u", 1, 32'h1000, 32'hB00, 32'h0, 32'h80, 32'hB00, 2'b00);

        // simultaneous trap+MRET from U, reset during the cause write
        q.push_back(mk(0, 1, 12'h341, 32'hC00, 0, 0, 2'b00));
        q.push_back(mk(0, 1, 12'h342, 32'd8,   0, 0, 2'b00));
        @(negedge clk);
        trap_valid = 1'b1; ret_valid = 1'b1; ret_is_m = 1'b1;
        trap_cause = 32'd8; trap_epc = 32'hC00; trap_tval = 32'h3;
        medeleg = 32'h0; mideleg = 32'h0; mtvec = 32'h8000_0000; mstatus_in = 32'h8;
        @(negedge clk);
        pop_check("both_epc");
        trap_valid = 1'b0; ret_valid = 1'b0;
        @(negedge clk);
        pop_check("both_cause");
        #2 reset = 1'b1;
        #1 compare("async_reset", mk(1, 0, 0, 0, 0, 0, 2'b11));
        @(negedge clk);
        reset = 1'b0;
        cur_mode = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            compare("after_abort", mk(1, 0, 0, 0, 0, 0, 2'b11));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameter: XLEN, 32, data and address width of all trap and CSR value ports.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- ready  out  1  block idle; a request is accepted when ready=1 and a valid input is 1.
- trap_valid  in  1  trap request.
- trap_cause  in  XLEN  mcause encoding; bit XLEN-1 = interrupt, bits 4:0 = code.
- trap_epc  in  XLEN  faulting/interrupted PC.
- trap_tval  in  XLEN  trap value.
- ret_valid  in  1  xRET request.
- ret_is_m  in  1  1 = MRET, 0 = SRET.
- medeleg, mideleg  in  XLEN  delegation masks.
- mtvec, stvec  in  XLEN  trap vectors; bits 1:0 = mode (1 = vectored).
- mepc_in, sepc_in  in  XLEN  current xEPC.
- mstatus_in  in  XLEN  current mstatus.
- csr_wen  out  1  CSR write strobe.
- csr_waddr  out  12  CSR write address.
- csr_wdata  out  XLEN  CSR write data.
- redirect_valid  out  1  one-cycle fetch redirect.
- redirect_pc  out  XLEN  redirect target.
- mode  out  2  current privilege mode.

Function
REQ-003 FSM states: IDLE, W_EPC, W_CAUSE, W_TVAL, W_STATUS, REDIR; ready=1 only in IDLE.
REQ-004 All request inputs, including mstatus_in, delegation masks, vectors and xEPC, SHALL be registered on the accept cycle; later input changes SHALL NOT affect the sequence.
REQ-005 Arbitration: if trap_valid and ret_valid are both 1 in IDLE, the trap is accepted and the return is ignored.
REQ-006 Target mode S iff mode != M and deleg[trap_cause[4:0]]=1, where deleg = mideleg for interrupts and medeleg otherwise; every other case targets M.
REQ-007 Trap path: accept at T; IDLE -> W_EPC -> W_CAUSE -> W_TVAL -> W_STATUS -> REDIR -> IDLE.
- csr_wen=1 at T+1..T+4 carrying epc, cause, tval, updated status.
- redirect_valid=1 at T+5 only.
REQ-008 Trap CSR addresses: M target 0x341, 0x342, 0x343, 0x300; S target 0x141, 0x142, 0x143, 0x100.
REQ-009 Status update for an M target: MPIE[7] <= MIE[3], MIE <= 0, MPP[12:11] <= mode; all other bits as sampled.
REQ-010 Status update for an S target: SPIE[5] <= SIE[1], SIE <= 0, SPP[8] <= mode[0]; all other bits as sampled.
REQ-011 Trap redirect_pc:
- base = {tvec[XLEN-1:2], 2'b00}.
- Add 4*code iff tvec[1:0]=1 and the trap is an interrupt.
- tvec[1:0] values 2 and 3 are treated as direct.
- Addition wraps modulo 2^XLEN.
REQ-012 Return path: accept at T; IDLE -> W_STATUS -> REDIR -> IDLE; status write at T+1, redirect_valid at T+2.
REQ-013 MRET behaviour:
- Writes 0x300 with MIE <= MPIE, MPIE <= 1, MPP <= 00.
- redirect_pc = mepc_in; new mode = sampled MPP.
- MPP=10 (H, unsupported) yields U.
REQ-014 SRET behaviour:
- Writes 0x100 with SIE <= SPIE, SPIE <= 1, SPP <= 0.
- redirect_pc = sepc_in; new mode = {1'b0, SPP}.
REQ-015 mode SHALL update in the REDIR cycle, registered, visible from the cycle after REDIR; mode SHALL NOT change at any other time.
REQ-016 When csr_wen=0, csr_waddr and csr_wdata SHALL be 0; when redirect_valid=0, redirect_pc SHALL be 0.
REQ-017 Requests presented while ready=0 SHALL be ignored, not queued.

Reset
REQ-018 reset SHALL act asynchronously and force state=IDLE, mode=11, ready=1 and every other output to 0.
REQ-019 Reset asserted mid-sequence SHALL abort the sequence: no further CSR writes and no redirect.

Verification
REQ-020 Trap from U, cause=8, medeleg=0, mtvec=0x8000_0000, mstatus_in=0x8 -> writes in order:
- 0x341 = epc, 0x342 = 8, 0x343 = tval, 0x300 = 0x80.
- Then redirect_pc = 0x8000_0000 at T+5, and mode = 11.
REQ-021 Trap from U, cause=0x8000_0005, mideleg=0x20, stvec=0x4000_0001 -> writes 0x141, 0x142, 0x143, 0x100 in order; redirect_pc = 0x4000_0014; mode = 01.
REQ-022 In M mode, cause=2 with medeleg=0xFFFF_FFFF -> M target (0x341 first) and mode stays 11.
REQ-023 MRET with mstatus_in=0x0000_1880, mepc_in=0x100 -> csr write 0x300 = 0x88 at T+1; redirect_pc = 0x100 at T+2; mode = 11.
REQ-024 trap_valid and ret_valid asserted together -> trap sequence only; reset asserted at T+2 -> no further csr_wen or redirect, mode = 11.
REQ-025 trap_valid pulsed while busy -> ignored; the sequence in progress completes unchanged.
